// File: rtl/breath_sequencer.sv
// LED breathing sequencer: ramp up, hold high, ramp down, hold low.
// Define BREATH_GAMMA_EN for a squared duty curve (one extra led stage).
module breath_sequencer #(
  parameter int CLK_DIV     = 100,
  parameter int PWM_STEPS   = 1000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] cycles_in,
  output logic       led,
  output logic       busy,
  output logic [9:0] level,
  output logic       done
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] TOP = 10'(PWM_STEPS);
  localparam logic [9:0] SLOT_MAX = 10'(PWM_STEPS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE, UP, HOLD_HI, DOWN, HOLD_LO
  } state_t;

  state_t state, state_n;
  logic [DW-1:0] div_cnt;
  logic [9:0] slot_cnt;
  logic [9:0] level_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [7:0] remaining, rem_n;
  logic inf, inf_n;
  logic stop_l, stop_n;
  logic done_n;
  logic tick, frame_end;

  assign busy = (state != IDLE);
  assign tick = busy && (div_cnt == DIV_MAX);
  assign frame_end = tick && (slot_cnt == SLOT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else if (!busy) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick)
        slot_cnt <= frame_end ? '0 : slot_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      level     <= '0;
      hold_cnt  <= '0;
      remaining <= '0;
      inf       <= 1'b0;
      stop_l    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      hold_cnt  <= hold_n;
      remaining <= rem_n;
      inf       <= inf_n;
      stop_l    <= stop_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    hold_n  = hold_cnt;
    rem_n   = remaining;
    inf_n   = inf;
    stop_n  = stop_l | (busy & stop);
    unique case (state)
      IDLE: begin
        stop_n = 1'b0;
        if (start) begin
          state_n = UP;
          level_n = '0;
          hold_n  = '0;
          rem_n   = cycles_in;
          inf_n   = (cycles_in == 8'd0);
        end
      end
      UP: if (frame_end) begin
        if (stop_l) begin
          state_n = DOWN;
        end else if (level == SLOT_MAX) begin
          level_n = TOP;
          hold_n  = '0;
          state_n = HOLD_HI;
        end else begin
          level_n = level + 10'd1;
        end
      end
      HOLD_HI: if (frame_end) begin
        if (stop_l || hold_cnt == HOLD_MAX) begin
          hold_n  = '0;
          state_n = DOWN;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      DOWN: if (frame_end) begin
        // a stop in the first UP frame arrives here at level 0
        if (level <= 10'd1) begin
          level_n = '0;
          hold_n  = '0;
          state_n = stop_l ? IDLE : HOLD_LO;
        end else begin
          level_n = level - 10'd1;
        end
      end
      HOLD_LO: if (frame_end) begin
        hold_n = hold_cnt + HW'(1);
        if (stop_l) begin
          state_n = IDLE;
        end else if (hold_cnt == HOLD_MAX) begin
          hold_n = '0;
          if (inf) begin
            state_n = UP;
          end else begin
            rem_n   = remaining - 8'd1;
            state_n = (remaining == 8'd1) ? IDLE : UP;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (busy && state_n == IDLE) begin
      stop_n = 1'b0;
      hold_n = '0;
    end
    done_n = busy && (state_n == IDLE);
  end

`ifdef BREATH_GAMMA_EN
  logic [19:0] sq;
  logic [9:0] lvl_eff, slot_d;
  logic act_d;

  assign sq = 20'(level) * 20'(level);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_eff <= '0;
      slot_d  <= '0;
      act_d   <= 1'b0;
      led     <= 1'b0;
    end else begin
      lvl_eff <= 10'(sq / 20'(PWM_STEPS));
      slot_d  <= slot_cnt;
      act_d   <= busy;
      led     <= act_d && (slot_d < lvl_eff);
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      led <= 1'b0;
    else
      led <= busy && (slot_cnt < level);
  end
`endif

endmodule

// File: tb/tb_breath_sequencer.sv
// Bench for breath_sequencer: frame-level plan model plus literal pins.
// Small parameters: 2 clks per slot, 4 slots per frame, 2 hold frames.
module tb_breath_sequencer;

  localparam int CD = 2;
  localparam int S  = 4;
  localparam int HF = 2;
  localparam int FR = CD * S;
`ifdef BREATH_GAMMA_EN
  localparam int LAT = 2;
  localparam int SUM1 = 36;
  localparam int SUMSTOP = 0;
`else
  localparam int LAT = 1;
  localparam int SUM1 = 48;
  localparam int SUMSTOP = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [7:0] cycles_in = 8'd0;
  logic led, busy, done;
  logic [9:0] level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  bit armed = 1'b0;
  int plan[$];
  int ledsum = 0;

  breath_sequencer #(
    .CLK_DIV(CD),
    .PWM_STEPS(S),
    .HOLD_FRAMES(HF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .cycles_in(cycles_in),
    .led(led),
    .busy(busy),
    .level(level),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int eff(input int l);
`ifdef BREATH_GAMMA_EN
    return (l * l) / S;
`else
    return l;
`endif
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // one full breath, one level per frame
  task automatic push_cycle();
    for (int l = 0; l < S; l++) plan.push_back(l);
    for (int h = 0; h < HF; h++) plan.push_back(S);
    for (int l = S; l >= 1; l--) plan.push_back(l);
    for (int h = 0; h < HF; h++) plan.push_back(0);
  endtask

  always @(negedge clk) begin
    int n, m, nf, e_lvl;
    bit e_led, e_busy, e_done;
    e_led = 0;
    e_busy = 0;
    e_done = 0;
    e_lvl = 0;
    if (armed) begin
      n = cyc - t0;
      nf = plan.size() * FR;
      if (n < nf) begin
        e_busy = 1;
        e_lvl = plan[n / FR];
      end
      e_done = (n == nf);
      m = n - LAT;
      if (m >= 0 && m < nf)
        e_led = ((m % FR) / CD) < eff(plan[m / FR]);
      ledsum += int'(led);
    end
    check("led", int'(led), int'(e_led));
    check("busy", int'(busy), int'(e_busy));
    check("level", int'(level), e_lvl);
    check("done", int'(done), int'(e_done));
  end

  task automatic do_start(input int cyc_in, input bit with_stop);
    @(negedge clk);
    cycles_in = 8'(cyc_in);
    start = 1'b1;
    stop = with_stop;
    ledsum = 0;
    @(posedge clk);
    #1;
    t0 = cyc;
    armed = 1'b1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic wait_n(input int target);
    while (cyc - t0 < target) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input int exp_n, input string nm);
    bit got;
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check({nm, "_seen"}, int'(got), 1);
    if (got) check({nm, "_time"}, cyc - t0, exp_n);
  endtask

  task automatic settle_sum(input int exp, input string nm);
    repeat (3) @(negedge clk);
    #1;
    check(nm, ledsum, exp);
  endtask

  task automatic pulse(input bit is_start);
    @(negedge clk);
    if (is_start) begin
      cycles_in = 8'd5;
      start = 1'b1;
    end else begin
      stop = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(level), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);

    // single cycle, with an ignored start mid-run
    armed = 1'b0;
    plan.delete();
    push_cycle();
    do_start(1, 1'b0);
    wait_n(20);
    pulse(1'b1);
    wait_n(40);
    check("hold_hi_level", int'(level), 4);
    wait_n(60);
    check("down_level", int'(level), 3);
    wait_done(200, 96, "cyc1_done");
    settle_sum(SUM1, "cyc1_ledsum");

    // stop while idle does nothing
    pulse(1'b0);
    repeat (10) @(negedge clk);

    // infinite run stopped in the level-1 UP frame
    armed = 1'b0;
    plan.delete();
    plan.push_back(0);
    plan.push_back(1);
    plan.push_back(1);
    do_start(0, 1'b0);
    wait_n(10);
    pulse(1'b0);
    wait_n(17);
    check("stop_down_level", int'(level), 1);
    check("stop_down_busy", int'(busy), 1);
    wait_done(100, 24, "stop_done");
    settle_sum(SUMSTOP, "stop_ledsum");

    // start and stop together: stop ignored, two cycles
    armed = 1'b0;
    plan.delete();
    push_cycle();
    push_cycle();
    do_start(2, 1'b1);
    wait_done(400, 192, "cyc2_done");
    settle_sum(2 * SUM1, "cyc2_ledsum");

    // reset mid HOLD_HI
    armed = 1'b0;
    plan.delete();
    push_cycle();
    do_start(1, 1'b0);
    wait_n(35);
    check("pre_rst_led", int'(led), 1);
    rst = 1'b0;
    armed = 1'b0;
    #1;
    check("async_led", int'(led), 0);
    check("async_busy", int'(busy), 0);
    check("async_level", int'(level), 0);
    check("async_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    armed = 1'b0;
    plan.delete();
    push_cycle();
    do_start(1, 1'b0);
    wait_done(200, 96, "post_rst_done");
    settle_sum(SUM1, "post_rst_ledsum");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
